rs232_event_assembler: RTL and testbench
========================================

RS232_EVENT_ASSEMBLER -- requirements
Module: rs232_event_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, giving the width of each received serial word; bit DATA_WIDTH is the frame marker.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of assembled events buffered; it is a power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum number of clk cycles allowed between first and second word.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port received_data, input, [DATA_WIDTH:1]: the word from the upstream RS232 receiver.
REQ-007 SHALL have port data_received, input, 1 bit: a single-cycle strobe marking received_data as valid.
REQ-008 SHALL have port event_data, output, [2*(DATA_WIDTH-1)-1:0]: the assembled event at the FIFO head.
REQ-009 SHALL have port event_valid, output, 1 bit: high when the FIFO is not empty.
REQ-010 SHALL have port event_ready, input, 1 bit: the consumer accepts the head event when this and event_valid are both high.
REQ-011 SHALL have port fifo_count, output, [$clog2(FIFO_DEPTH):0]: the number of events held.
REQ-012 SHALL have port framing_error, output, 1 bit: a one-cycle pulse on each framing fault.
REQ-013 SHALL have port overflow, output, 1 bit: a one-cycle pulse when a completed event is dropped.
REQ-014 SHALL have port drop_count, output, 8 bits: a saturating count of dropped events.

Function
REQ-015 SHALL treat a word with received_data[DATA_WIDTH]=1 as FIRST and a word with that bit at 0 as SECOND; payload is received_data[DATA_WIDTH-1:1].
REQ-016 SHALL implement FSM states WAIT_FIRST and WAIT_SECOND.
REQ-017 WAIT_FIRST: on a FIRST strobe, SHALL latch the payload as the high half and go to WAIT_SECOND.
REQ-018 WAIT_FIRST: on a SECOND strobe, SHALL pulse framing_error, discard the word and remain in WAIT_FIRST.
REQ-019 WAIT_SECOND: on a SECOND strobe, SHALL form event {high payload, low payload}, present it for push and return to WAIT_FIRST.
REQ-020 WAIT_SECOND: on a FIRST strobe, SHALL pulse framing_error, replace the high half with the new payload, restart the timeout and remain in WAIT_SECOND.
REQ-021 WAIT_SECOND: SHALL count cycles without a strobe; on reaching TIMEOUT_CYCLES it SHALL discard the high half, pulse framing_error and go to WAIT_FIRST.
REQ-022 The timeout counter SHALL clear on every strobe and on entry to WAIT_SECOND.
REQ-023 A push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-024 When full with no pop, SHALL drop the event, pulse overflow for one cycle and increment drop_count, saturating at 255.
REQ-025 Pop SHALL occur when event_valid and event_ready are both high; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-026 Latency: a SECOND strobe at cycle N into an empty FIFO SHALL give event_valid=1 with the new event_data at cycle N+1.
REQ-027 event_data SHALL hold stable while event_valid=1 and event_ready=0.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; ordering SHALL be strictly first-in, first-out.
REQ-029 A strobe that coincides with a timeout expiry SHALL be processed as in WAIT_SECOND, and the timeout SHALL be ignored.
REQ-030 event_ready while event_valid=0 SHALL have no effect.

Reset
REQ-031 While reset=1, SHALL force: FSM to WAIT_FIRST, FIFO empty, fifo_count=0, event_valid=0, event_data=0, framing_error=0, overflow=0, drop_count=0, timeout counter=0.
REQ-032 Reset asserted mid-event SHALL discard the latched high half; no partial event SHALL appear after reset deasserts.
REQ-033 Strobes present during reset SHALL be ignored.

Verification
REQ-034 Basic: strobe 9'h1A5 then 9'h03C, event_ready=1 -> event_data=16'hA53C with event_valid high for 1 cycle at N+1, framing_error=0.
REQ-035 Framing: strobe 9'h011 in WAIT_FIRST -> framing_error pulse, no event; then 9'h122, 9'h144, 9'h055 -> one framing_error pulse, then one event 16'h4455.
REQ-036 Backpressure: event_ready=0, push 5 events with FIFO_DEPTH=4 -> fifo_count=4, overflow pulses once, drop_count=1; then drain and confirm events 1-4 in order.
REQ-037 Full with simultaneous pop: FIFO full, event_ready=1 in the same cycle as the completing SECOND strobe -> no overflow, fifo_count stays 4.
REQ-038 Timeout: TIMEOUT_CYCLES=8, FIRST strobe, then no strobe for 8 cycles -> framing_error pulse, FSM returns to WAIT_FIRST; a later SECOND strobe raises another framing_error.
REQ-039 Reset mid-event: FIRST strobe, then reset, then SECOND strobe -> no event and framing_error pulses; all outputs read 0 during reset.

Source files
------------

// File: rtl/rs232_event_assembler.sv
// Pairs FIRST/SECOND serial words into one event and queues events in a small FIFO.
// Framing faults, timeouts and FIFO drops are reported as one-cycle pulses.
module rs232_event_assembler #(
    parameter int DATA_WIDTH     = 9,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH:1]             received_data,
    input  logic                            data_received,
    output logic [2*(DATA_WIDTH-1)-1:0]     event_data,
    output logic                            event_valid,
    input  logic                            event_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            framing_error,
    output logic                            overflow,
    output logic [7:0]                      drop_count
);
    localparam int PW = DATA_WIDTH - 1;
    localparam int EW = 2 * PW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    typedef enum logic {WAIT_FIRST, WAIT_SECOND} state_t;

    state_t        state;
    logic [PW-1:0] high;
    logic [TW-1:0] tcnt;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          is_first;
    logic [PW-1:0] payload;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

    assign is_first = received_data[DATA_WIDTH];
    assign payload  = received_data[DATA_WIDTH-1:1];

    // The completing SECOND word is written in the same edge it arrives, giving one-cycle latency.
    assign push  = data_received && (state == WAIT_SECOND) && !is_first;
    assign pop   = event_valid && event_ready;
    assign full  = (fifo_count == DEPTH_C);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign event_valid = (fifo_count != '0);
    assign event_data  = event_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= WAIT_FIRST;
            high          <= '0;
            tcnt          <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            case (state)
                WAIT_FIRST: begin
                    tcnt <= '0;
                    if (data_received) begin
                        if (is_first) begin
                            high  <= payload;
                            state <= WAIT_SECOND;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end
                end
                WAIT_SECOND: begin
                    // A strobe always wins over a coincident timeout expiry.
                    if (data_received) begin
                        tcnt <= '0;
                        if (is_first) begin
                            high          <= payload;
                            framing_error <= 1'b1;
                        end else begin
                            state <= WAIT_FIRST;
                        end
                    end else if (tcnt == TO_LAST) begin
                        tcnt          <= '0;
                        high          <= '0;
                        framing_error <= 1'b1;
                        state         <= WAIT_FIRST;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= WAIT_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {high, payload};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= drop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_rs232_event_assembler.sv
// Bench for rs232_event_assembler: a queue-based reference model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_rs232_event_assembler;
    localparam int DW    = 9;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [DW:1] received_data = '0;
    logic        data_received = 1'b0;
    logic [15:0] event_data;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        framing_error;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    rs232_event_assembler #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .received_data(received_data),
        .data_received(data_received),
        .event_data   (event_data),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .fifo_count   (fifo_count),
        .framing_error(framing_error),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending high half, idle cycles since last strobe, event queue.
    logic [15:0] q[$];
    bit          m_pending = 0;
    logic [7:0]  m_high = '0;
    int          m_idle = 0;
    bit          m_ferr = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;
    bit          m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_pending = 0; m_high = '0; m_idle = 0;
            m_ferr = 0; m_ovf = 0; m_drop = 0;
        end else begin
            m_ferr = 0;
            m_ovf  = 0;
            m_pop  = (q.size() != 0) && event_ready;
            if (m_pop) void'(q.pop_front());
            if (data_received) begin
                m_idle = 0;
                if (received_data[DW]) begin
                    if (m_pending) m_ferr = 1;
                    m_pending = 1;
                    m_high = received_data[DW-1:1];
                end else if (!m_pending) begin
                    m_ferr = 1;
                end else begin
                    m_pending = 0;
                    if (q.size() < DEPTH) q.push_back({m_high, received_data[DW-1:1]});
                    else begin
                        m_ovf = 1;
                        if (m_drop < 255) m_drop++;
                    end
                end
            end else if (m_pending) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_ferr = 1; m_pending = 0; m_idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("event_valid", {31'd0, event_valid}, {31'd0, q.size() != 0});
        chk("event_data", {16'd0, event_data}, (q.size() != 0) ? {16'd0, q[0]} : 32'd0);
        chk("fifo_count", {29'd0, fifo_count}, q.size());
        chk("framing_error", {31'd0, framing_error}, {31'd0, m_ferr});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_count", {24'd0, drop_count}, m_drop);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents one word for exactly one sampling edge; returns 2ns after that edge.
    task automatic send(input logic [DW:1] w);
        received_data = w;
        data_received = 1'b1;
        tick();
        data_received = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_valid", {31'd0, event_valid}, 32'd0);
        chk("reset_count", {29'd0, fifo_count}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic pairing
        event_ready = 1'b1;
        send(9'h1A5);
        send(9'h03C);
        chk("basic_valid", {31'd0, event_valid}, 32'd1);
        chk("basic_data", {16'd0, event_data}, 32'h0000A53C);
        chk("basic_ferr", {31'd0, framing_error}, 32'd0);
        tick();
        chk("basic_popped", {31'd0, event_valid}, 32'd0);

        // Framing faults
        send(9'h011);
        chk("orphan_second_ferr", {31'd0, framing_error}, 32'd1);
        chk("orphan_second_noevt", {31'd0, event_valid}, 32'd0);
        send(9'h122);
        send(9'h144);
        chk("double_first_ferr", {31'd0, framing_error}, 32'd1);
        send(9'h055);
        chk("restart_data", {16'd0, event_data}, 32'h00004455);
        chk("restart_ferr", {31'd0, framing_error}, 32'd0);
        tick();

        // Backpressure and overflow
        event_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send({1'b1, 8'(8'h10 + i)});
            send({1'b0, 8'(8'h20 + i)});
        end
        chk("bp_count", {29'd0, fifo_count}, 32'd4);
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        chk("bp_drops", {24'd0, drop_count}, 32'd1);
        tick();
        chk("bp_overflow_end", {31'd0, overflow}, 32'd0);
        event_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", {16'd0, event_data}, {16'd0, 8'(8'h10 + i), 8'(8'h20 + i)});
            tick();
        end
        chk("bp_empty", {31'd0, event_valid}, 32'd0);

        // Full FIFO with a pop on the completing edge
        event_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send({1'b1, 8'(8'h30 + i)});
            send({1'b0, 8'(8'h40 + i)});
        end
        send(9'h150);
        received_data = 9'h060;
        data_received = 1'b1;
        event_ready   = 1'b1;
        tick();
        data_received = 1'b0;
        event_ready   = 1'b0;
        chk("fullpop_overflow", {31'd0, overflow}, 32'd0);
        chk("fullpop_count", {29'd0, fifo_count}, 32'd4);
        chk("fullpop_head", {16'd0, event_data}, 32'h00003141);
        event_ready = 1'b1;
        repeat (6) tick();
        chk("fullpop_drained", {29'd0, fifo_count}, 32'd0);

        // Timeout after TMO idle cycles
        send(9'h1AA);
        repeat (TMO - 1) tick();
        chk("tmo_not_yet", {31'd0, framing_error}, 32'd0);
        tick();
        chk("tmo_fires", {31'd0, framing_error}, 32'd1);
        send(9'h033);
        chk("tmo_then_second", {31'd0, framing_error}, 32'd1);
        chk("tmo_no_event", {31'd0, event_valid}, 32'd0);

        // Strobe coinciding with expiry is processed normally
        send(9'h1BB);
        repeat (TMO - 1) tick();
        send(9'h0CC);
        chk("edge_data", {16'd0, event_data}, 32'h0000BBCC);
        chk("edge_ferr", {31'd0, framing_error}, 32'd0);
        tick();

        // Reset mid-event, with a strobe held during reset
        event_ready = 1'b0;
        send({1'b1, 8'h77});
        send({1'b0, 8'h88});
        send(9'h1DD);
        reset = 1'b1;
        received_data = 9'h0EE;
        data_received = 1'b1;
        repeat (2) tick();
        chk("rst_valid", {31'd0, event_valid}, 32'd0);
        chk("rst_data", {16'd0, event_data}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_ferr", {31'd0, framing_error}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_drops", {24'd0, drop_count}, 32'd0);
        data_received = 1'b0;
        reset = 1'b0;
        tick();
        send(9'h0EE);
        chk("post_rst_ferr", {31'd0, framing_error}, 32'd1);
        chk("post_rst_noevt", {31'd0, event_valid}, 32'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
